// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared constants and types for the LCD message sequencer: driver
//   function codes, sequencer state encoding, HD44780 init commands and
//   DDRAM line addresses.
package lcd_pkg;

  localparam logic [1:0] LCD_FUNC_CMD  = 2'b00;  // RS=0
  localparam logic [1:0] LCD_FUNC_DATA = 2'b01;  // RS=1

  typedef enum logic [2:0] {
    ST_PWRUP      = 3'd0,
    ST_INIT_ISSUE = 3'd1,
    ST_INIT_WAIT  = 3'd2,
    ST_READY      = 3'd3,
    ST_WR_ISSUE   = 3'd4,
    ST_WR_WAIT    = 3'd5
  } lcd_seq_state_e;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;  // increment, no shift

  localparam logic [7:0] LCD_ADDR_LINE1 = 8'h80;
  localparam logic [7:0] LCD_ADDR_LINE2 = 8'hC0;

  localparam logic [1:0] LCD_INIT_LAST = 2'd3;   // index of last init item
  localparam logic [5:0] LCD_WR_LAST   = 6'd33;  // index of last write item

  function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_CMD_FUNCSET;
      2'd1:    cmd = LCD_CMD_DISPON;
      2'd2:    cmd = LCD_CMD_CLEAR;
      default: cmd = LCD_CMD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_pwrup_timer.sv
// lcd_pwrup_timer
//   Counts CYCLES enabled clock cycles after reset and then stays expired.
//   The counter saturates at CYCLES and never wraps.
//   Ports:
//     i_clk   system clock
//     i_rst   asynchronous active-high reset (clears the count)
//     i_en    count enable
//     o_done  high during the last counted cycle and every enabled cycle
//             after it, so a registered consumer moves on exactly after
//             CYCLES edges
module lcd_pwrup_timer #(
  parameter int CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_done
);

  localparam int CNT_W = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = (CYCLES < 1) ? '0 : CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = i_en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/lcd_msg_sequencer.sv
// lcd_msg_sequencer
//   Waits out LCD power-up, issues the HD44780 init list, then on request
//   writes two 16-character lines through the LCD timer/driver, one
//   transaction at a time, waiting for the driver's done pulse in between.
//   Ports:
//     i_clk, i_rst        clock, asynchronous active-high reset
//     i_start             write request (pulse or level); remembered if it
//                         arrives before init completes
//     i_line1, i_line2    16 ASCII chars each, leftmost char in the MSByte
//     i_lcd_done          driver: current transaction complete
//     o_lcd_en            one-cycle transaction strobe to the driver
//     o_lcd_data/func     transaction payload, stable until the next strobe
//     o_ready / o_busy    idle after init / anything else
//     o_done              one-cycle pulse at the end of a two-line write
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   PWRUP      | power-up wait
//   INIT_ISSUE | strobe init command idx
//   INIT_WAIT  | wait driver done for init command idx
//   READY      | idle; start (or pending start) snapshots the lines
//   WR_ISSUE   | strobe write item idx (first cycle after READY is the
//              | snapshot cycle, strobe follows)
//   WR_WAIT    | wait driver done for write item idx
module lcd_msg_sequencer
  import lcd_pkg::*;
#(
  parameter int FREQ      = 50_000_000,
  parameter int PWRUP_US  = 20_000,
  parameter int SIZE_DATA = 8,
  parameter int SIZE_FUNC = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [127:0]         i_line1,
  input  logic [127:0]         i_line2,
  input  logic                 i_lcd_done,
  output logic                 o_lcd_en,
  output logic [SIZE_DATA-1:0] o_lcd_data,
  output logic [SIZE_FUNC-1:0] o_lcd_func,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int PWRUP_CYCLES = PWRUP_US * (FREQ / 1_000_000);

  lcd_seq_state_e state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic           pend_q, pend_d;
  logic [255:0]   snap_q, snap_d;

  logic                 lcd_en_q, lcd_en_d;
  logic [SIZE_DATA-1:0] lcd_data_q, lcd_data_d;
  logic [SIZE_FUNC-1:0] lcd_func_q, lcd_func_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic pwrup_done;

  lcd_pwrup_timer #(
    .CYCLES (PWRUP_CYCLES)
  ) u_pwrup_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state_q == ST_PWRUP),
    .o_done (pwrup_done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    done_d  = 1'b0;

    if (i_start && (state_q inside {ST_PWRUP, ST_INIT_ISSUE, ST_INIT_WAIT})) begin
      pend_d = 1'b1;
    end

    case (state_q)
      ST_PWRUP: begin
        if (pwrup_done) begin
          state_d = ST_INIT_ISSUE;
          idx_d   = '0;
        end
      end
      ST_INIT_ISSUE: begin
        if (lcd_en_q) state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (i_lcd_done) begin
          if (idx_q[1:0] == LCD_INIT_LAST) begin
            state_d = ST_READY;
            idx_d   = '0;
          end else begin
            state_d = ST_INIT_ISSUE;
            idx_d   = idx_q + 6'd1;
          end
        end
      end
      ST_READY: begin
        if (i_start || pend_q) begin
          snap_d  = {i_line1, i_line2};
          pend_d  = 1'b0;
          state_d = ST_WR_ISSUE;
          idx_d   = '0;
        end
      end
      ST_WR_ISSUE: begin
        if (lcd_en_q) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (i_lcd_done) begin
          if (idx_q == LCD_WR_LAST) begin
            state_d = ST_READY;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WR_ISSUE;
            idx_d   = idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_PWRUP;
        idx_d   = '0;
      end
    endcase
  end

  // Item -> (byte, func) mux, evaluated for the state being entered so the
  // registered outputs line up with the strobe. Write items 1..16 map to
  // chars 0..15 and items 18..33 to chars 16..31 of the snapshot; 5-bit
  // wrap-around makes "idx-2" correct for items 32 and 33.
  logic [4:0] char_idx;
  logic [7:0] bit_hi;
  logic [7:0] item_byte;
  logic [1:0] item_func;

  always_comb begin
    char_idx   = '0;
    bit_hi     = 8'd255;
    item_byte  = 8'h00;
    item_func  = LCD_FUNC_CMD;
    lcd_en_d   = 1'b0;
    lcd_data_d = lcd_data_q;
    lcd_func_d = lcd_func_q;

    if (state_d == ST_INIT_ISSUE) begin
      item_byte = lcd_init_cmd(idx_d[1:0]);
    end else begin
      char_idx = (idx_d <= 6'd16) ? (idx_d[4:0] - 5'd1) : (idx_d[4:0] - 5'd2);
      bit_hi   = 8'd255 - {char_idx, 3'b000};
      if (idx_d == 6'd0) begin
        item_byte = LCD_ADDR_LINE1;
      end else if (idx_d == 6'd17) begin
        item_byte = LCD_ADDR_LINE2;
      end else begin
        item_byte = snap_q[bit_hi -: 8];
        item_func = LCD_FUNC_DATA;
      end
    end

    if ((state_d == ST_INIT_ISSUE) || (state_d == ST_WR_ISSUE)) begin
      // Leaving READY spends one cycle taking the snapshot before strobing.
      lcd_en_d   = (state_q != ST_READY);
      lcd_data_d = SIZE_DATA'(item_byte);
      lcd_func_d = SIZE_FUNC'(item_func);
    end

    ready_d = (state_d == ST_READY);
    busy_d  = !ready_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_PWRUP;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      snap_q     <= '0;
      lcd_en_q   <= 1'b0;
      lcd_data_q <= '0;
      lcd_func_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      snap_q     <= snap_d;
      lcd_en_q   <= lcd_en_d;
      lcd_data_q <= lcd_data_d;
      lcd_func_q <= lcd_func_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_lcd_en   = lcd_en_q;
  assign o_lcd_data = lcd_data_q;
  assign o_lcd_func = lcd_func_q;
  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// tb_lcd_msg_sequencer
//   Bench for lcd_msg_sequencer with a 10-cycle power-up wait. A responder
//   answers every strobe with a done pulse after a programmable delay; a
//   monitor records every strobe, done pulse and ready edge. Expected
//   transaction streams come from the init list and the line text directly.
module tb_lcd_msg_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start;
  logic [127:0] line1, line2;
  logic         resp_done, man_done;
  logic         lcd_done;
  logic         o_lcd_en;
  logic [7:0]   o_lcd_data;
  logic [1:0]   o_lcd_func;
  logic         o_ready, o_busy, o_done;

  assign lcd_done = resp_done | man_done;

  lcd_msg_sequencer #(
    .FREQ      (10_000_000),
    .PWRUP_US  (1),
    .SIZE_DATA (8),
    .SIZE_FUNC (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_line1    (line1),
    .i_line2    (line2),
    .i_lcd_done (lcd_done),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_data (o_lcd_data),
    .o_lcd_func (o_lcd_func),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- monitor ----------------
  logic [9:0] cap_q[$];
  int         cap_cyc[$];
  logic [9:0] exp_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       done_ready = 1'b0;
  int         last_done_cyc = 0;
  int         ready_rise_cyc = 0;
  logic       ready_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (o_lcd_en) begin
        cap_q.push_back({o_lcd_func, o_lcd_data});
        cap_cyc.push_back(cyc);
      end
      if (lcd_done) last_done_cyc = cyc;
      if (o_done) begin
        done_cnt++;
        done_cyc   = cyc;
        done_ready = o_ready;
      end
      if (o_ready && !ready_prev) ready_rise_cyc = cyc;
    end
    ready_prev = o_ready;
  end

  // ---------------- responder ----------------
  logic resp_on  = 1'b1;
  int   resp_dly = 5;
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_on && o_lcd_en) begin
        repeat (resp_dly) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic push_init();
    logic [7:0] init_tab[4];
    init_tab = '{8'h38, 8'h0C, 8'h01, 8'h06};
    for (int k = 0; k < 4; k++) exp_q.push_back({2'b00, init_tab[k]});
  endtask

  task automatic push_write(input logic [127:0] a, input logic [127:0] b);
    exp_q.push_back({2'b00, 8'h80});
    for (int k = 0; k < 16; k++) exp_q.push_back({2'b01, a[127-8*k -: 8]});
    exp_q.push_back({2'b00, 8'hC0});
    for (int k = 0; k < 16; k++) exp_q.push_back({2'b01, b[127-8*k -: 8]});
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) check($sformatf("%s_item%0d", tag, i), {22'd0, cap_q[i]}, {22'd0, exp_q[i]});
    end
  endtask

  task automatic wait_cap(input int n, input int budget, input string name);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, cap_q.size() >= n, 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(name, done_cnt >= n, 1);
  endtask

  task automatic wait_ready(input int budget, input string name);
    int k = 0;
    while (!o_ready && k < budget) begin
      tick();
      k++;
    end
    check(name, o_ready, 1);
  endtask

  task automatic pulse_start(output int st_cyc);
    @(posedge clk);
    #1 start = 1'b1;
    st_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  typedef struct {
    logic [127:0] l1;
    logic [127:0] l2;
    int           dly;
    logic [7:0]   exp_c1;
    logic [7:0]   exp_c18;
    logic [7:0]   exp_last;
  } wr_vec_t;

  wr_vec_t vecs[3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st_cyc, rel_cyc, first_done, init_ready, k, unstable;
    logic [127:0] la, lb;

    vecs[0] = '{"HELLO WORLD     ", "VITERBI DECODER ", 5, 8'h48, 8'h56, 8'h20};
    vecs[1] = '{"0123456789ABCDEF", "fedcba9876543210", 1, 8'h30, 8'h66, 8'h30};
    vecs[2] = '{"ABCDEFGHIJKLMNOP", "abcdefghijklmnop", 3, 8'h41, 8'h61, 8'h70};

    start = 1'b0; line1 = '0; line2 = '0; man_done = 1'b0;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    tick();
    check("rst_en", o_lcd_en, 0);
    check("rst_data", o_lcd_data, 8'h00);
    check("rst_func", o_lcd_func, 2'b00);
    check("rst_ready", o_ready, 0);
    check("rst_busy", o_busy, 1);
    check("rst_done", o_done, 0);
    rel_cyc = cyc;
    rst = 1'b0;

    // ---- power-up and init ----
    clear_cap();
    push_init();
    tick();
    check("pwrup_busy", o_busy, 1);
    wait_cap(4, 300, "init_strobes");
    wait_ready(100, "init_ready");
    cmp_stream("init");
    if (cap_cyc.size() >= 2) begin
      check("pwrup_latency", cap_cyc[0] - rel_cyc, 10);
      check("item_gap", cap_cyc[1] - cap_cyc[0], 6);
    end
    check("ready_after_done", ready_rise_cyc - last_done_cyc, 1);
    check("init_busy", o_busy, 0);
    check("init_no_done", done_cnt, 0);

    // ---- table-driven line writes ----
    for (int v = 0; v < 3; v++) begin
      clear_cap();
      resp_dly = vecs[v].dly;
      line1 = vecs[v].l1;
      line2 = vecs[v].l2;
      push_write(line1, line2);
      pulse_start(st_cyc);
      wait_done(1, 34 * (vecs[v].dly + 3) + 50, $sformatf("wr%0d_done", v));
      repeat (5) tick();
      cmp_stream($sformatf("wr%0d", v));
      check($sformatf("wr%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("wr%0d_done_ready", v), done_ready, 1);
      check($sformatf("wr%0d_done_lat", v), done_cyc - last_done_cyc, 1);
      if (cap_q.size() == 34) begin
        check($sformatf("wr%0d_start_lat", v), cap_cyc[0] - st_cyc, 2);
        check($sformatf("wr%0d_c1", v), cap_q[1][7:0], vecs[v].exp_c1);
        check($sformatf("wr%0d_c18", v), cap_q[18][7:0], vecs[v].exp_c18);
        check($sformatf("wr%0d_last", v), cap_q[33][7:0], vecs[v].exp_last);
      end
    end

    // ---- stray done in READY ----
    clear_cap();
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    repeat (10) tick();
    check("stray_no_strobe", cap_q.size(), 0);
    check("stray_ready", o_ready, 1);

    // ---- start held as a level: accepted again in the o_done cycle ----
    clear_cap();
    resp_dly = 2;
    line1 = vecs[0].l1;
    line2 = vecs[0].l2;
    push_write(line1, line2);
    push_write(line1, line2);
    @(posedge clk);
    #1 start = 1'b1;
    wait_done(1, 400, "b2b_first_done");
    first_done = done_cyc;
    wait_cap(35, 20, "b2b_second_start");
    start = 1'b0;
    line1 = vecs[1].l1;
    line2 = vecs[1].l2;
    wait_done(2, 400, "b2b_second_done");
    repeat (20) tick();
    cmp_stream("b2b");
    check("b2b_done_cnt", done_cnt, 2);
    if (cap_cyc.size() > 34) check("b2b_restart_lat", cap_cyc[34] - first_done, 2);

    // ---- long driver delay: payload held throughout WAIT ----
    clear_cap();
    resp_dly = 1000;
    line1 = vecs[2].l1;
    line2 = vecs[2].l2;
    push_write(line1, line2);
    pulse_start(st_cyc);
    wait_cap(1, 10, "hold_first_strobe");
    repeat (2) tick();
    resp_dly = 4;
    unstable = 0;
    repeat (990) begin
      tick();
      if (o_lcd_data !== 8'h80 || o_lcd_func !== 2'b00 || o_lcd_en !== 1'b0 || o_busy !== 1'b1)
        unstable++;
    end
    check("hold_stable", unstable, 0);
    check("hold_no_strobe", cap_q.size(), 1);
    wait_done(1, 400, "hold_done");
    repeat (3) tick();
    cmp_stream("hold");

    // ---- reset at item 20, then early start during power-up ----
    clear_cap();
    resp_dly = 5;
    line1 = vecs[0].l1;
    line2 = vecs[0].l2;
    pulse_start(st_cyc);
    wait_cap(21, 400, "mid_reach_item20");
    rst = 1'b1;
    #1;
    check("mid_en_drop", o_lcd_en, 0);
    check("mid_busy", o_busy, 1);
    check("mid_ready", o_ready, 0);
    check("mid_data", o_lcd_data, 8'h00);
    repeat (2) @(posedge clk);
    tick();
    rst = 1'b0;
    rel_cyc = cyc;
    clear_cap();
    line1 = vecs[1].l1;
    line2 = vecs[1].l2;
    push_init();
    push_write(line1, line2);
    repeat (3) tick();
    pulse_start(st_cyc);
    wait_cap(5, 300, "early_write_begins");
    init_ready = ready_rise_cyc;
    for (int p = 0; p < 3; p++) begin
      repeat (15) tick();
      pulse_start(st_cyc);
    end
    wait_done(1, 400, "early_done");
    repeat (30) tick();
    cmp_stream("early");
    check("early_done_cnt", done_cnt, 1);
    if (cap_cyc.size() >= 5) begin
      check("early_pwrup_lat", cap_cyc[0] - rel_cyc, 10);
      check("early_pending_lat", cap_cyc[4] - init_ready, 2);
    end

    // ---- randomized writes against the stream model ----
    for (int it = 0; it < 8; it++) begin
      clear_cap();
      resp_dly = $urandom_range(1, 8);
      la = {$urandom, $urandom, $urandom, $urandom};
      lb = {$urandom, $urandom, $urandom, $urandom};
      line1 = la;
      line2 = lb;
      push_write(la, lb);
      repeat ($urandom_range(0, 5)) tick();
      pulse_start(st_cyc);
      k = 0;
      while (cap_q.size() < 34 && k < 400) begin
        tick();
        start = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) line1 = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) line2 = {$urandom, $urandom, $urandom, $urandom};
        k++;
      end
      start = 1'b0;
      wait_done(1, 100, $sformatf("rnd%0d_done", it));
      repeat (3) tick();
      cmp_stream($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_done_cnt", it), done_cnt, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_msg_sequencer.md
# lcd_msg_sequencer

- Sequences the LCD timer/driver block: after power-up it issues the HD44780 init command list, then on request writes two 16-character lines.
- Drives the driver's enable/data/function inputs one transaction at a time and waits for its done pulse before issuing the next.
- Sits between user logic (which supplies 2×16 ASCII characters) and the LCD driver; per-command execution delays remain the driver's responsibility.

## Interface
Parameters:
- FREQ, 50_000_000, clock frequency in Hz
- PWRUP_US, 20_000, power-up wait before first init command, in µs
- SIZE_DATA, 8, LCD data width
- SIZE_FUNC, 2, driver function-code width

Ports:
- i_clk  in  1  system clock, single clock domain
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  request a two-line write; pulse or level
- i_line1  in  128  line-1 text; char 0 (leftmost) = [127:120]
- i_line2  in  128  line-2 text, same ordering
- i_lcd_done  in  1  one-cycle pulse from driver: current transaction complete
- o_lcd_en  out  1  one-cycle transaction strobe to driver
- o_lcd_data  out  SIZE_DATA  byte for current transaction
- o_lcd_func  out  SIZE_FUNC  2'b00 = command write (RS=0), 2'b01 = data write (RS=1); 2'b1x never driven
- o_ready  out  1  init complete and idle
- o_busy  out  1  power-up, init or write in progress
- o_done  out  1  one-cycle pulse when a two-line write finishes

## Operation
- States: PWRUP, INIT_ISSUE, INIT_WAIT, READY, WR_ISSUE, WR_WAIT.
- PWRUP: counter counts PWRUP_US*(FREQ/1_000_000) cycles, then goes to INIT_ISSUE with item index 0.
- Init list, all func=00: 0x38, 0x0C, 0x01, 0x06.
- *_ISSUE: one cycle; o_lcd_en=1, o_lcd_data/o_lcd_func valid; next state is *_WAIT.
- *_WAIT: o_lcd_data/o_lcd_func held stable; on i_lcd_done, advance the index and go to *_ISSUE, or to the exit state after the last item.
- After init item 3 completes: go to READY.
- READY with i_start=1 or a pending flag: snapshot i_line1/i_line2 into a 256-bit register, clear pending, go to WR_ISSUE with index 0.
- Write list, 34 items, index 0..33:
  - item 0: cmd 0x80
  - items 1–16: data chars 0–15 of line 1
  - item 17: cmd 0xC0
  - items 18–33: data chars 0–15 of line 2
- After item 33 completes: o_done=1 for one cycle and return to READY.
- i_start during PWRUP or INIT_*: set a one-bit pending flag, served on entering READY.
- i_start during WR_*: ignored. The snapshot is not updated mid-write.
- i_lcd_done outside *_WAIT: ignored.
- i_lcd_done in the same cycle as *_ISSUE: ignored. The done must arrive after the strobe.

## Timing
- Reset values:
  - state = PWRUP, all counters and indices 0, pending = 0
  - o_lcd_en = 0, o_lcd_data = 0x00, o_lcd_func = 2'b00
  - o_ready = 0, o_busy = 1, o_done = 0
- All outputs are registered.
- o_ready = (state == READY); o_busy = !o_ready.
- Start latency: i_start sampled high in READY → o_lcd_en high 2 cycles later (snapshot cycle, then ISSUE).
- Item-to-item latency: i_lcd_done in WAIT → next o_lcd_en exactly 1 cycle later.
- o_done asserts the cycle after the last i_lcd_done. o_ready asserts in the same cycle.
- i_start high in the same cycle o_done is high: accepted. The new write begins immediately.
- Reset mid-operation: abandons any transaction (o_lcd_en low immediately) and restarts from PWRUP with the full init sequence.
- Power-up counter: width $clog2(PWRUP_US*(FREQ/1_000_000)+1). It saturates and does not wrap.

## Structure
- Package lcd_pkg holds:
  - func-code constants: LCD_FUNC_CMD = 2'b00, LCD_FUNC_DATA = 2'b01
  - state enum lcd_seq_state_e
  - init ROM constants: LCD_CMD_FUNCSET 0x38, LCD_CMD_DISPON 0x0C, LCD_CMD_CLEAR 0x01, LCD_CMD_ENTRY 0x06
  - line address constants 0x80, 0xC0
- One natural sub-module: lcd_pwrup_timer, a parameterised cycle countdown with a done flag.
- The item→(data, func) mux stays inline.

## Test plan
- Reset and power-up (PWRUP_US=1, FREQ=10_000_000):
  - outputs hold their reset values; first o_lcd_en occurs at cycle 10 after reset release
  - o_lcd_data=0x38, func=00
- Init sequence, bench pulses i_lcd_done 5 cycles after each strobe:
  - strobes carry 0x38, 0x0C, 0x01, 0x06 with func=00
  - o_ready rises 1 cycle after the 4th done
- Line write, i_line1="HELLO WORLD     ", i_line2="VITERBI DECODER ":
  - 34 strobes in order: 0x80; 0x48 … 0x20 (func=01); 0xC0; 0x56 … 0x20
  - one o_done pulse
- Early start: i_start pulsed during PWRUP:
  - write begins automatically after init
  - i_start during the write is ignored; exactly one o_done
- Handshake robustness:
  - a stray i_lcd_done in READY causes no strobe
  - i_lcd_done delayed 1000 cycles: o_lcd_data stays stable throughout WAIT
- Mid-write reset: i_rst asserted at item 20:
  - o_lcd_en drops immediately, state returns to PWRUP
  - init is replayed from 0x38
